// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Purpose  : Shared definitions for the hazard scoreboard: default register
//            address width, register count and the hazard-cause encoding
//            used to prioritise and debug stall reasons.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_BUS = 5;
  localparam int REG_NUM      = 2 ** REG_ADDR_BUS;

  typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;

  typedef enum logic [2:0] {
    HZ_NONE = 3'd0,
    HZ_LU   = 3'd1,
    HZ_RAW  = 3'd2,
    HZ_WAW  = 3'd3,
    HZ_CAP  = 3'd4
  } hz_cause_e;

  // Highest-priority cause of a stall; HZ_NONE when the ID instruction may go.
  function automatic hz_cause_e hz_prio(input logic lu, input logic raw,
                                        input logic waw, input logic cap);
    hz_cause_e c;
    c = HZ_NONE;
    if (cap) c = HZ_CAP;
    if (waw) c = HZ_WAW;
    if (raw) c = HZ_RAW;
    if (lu)  c = HZ_LU;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_sb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_sb_regfile
// Purpose  : Pending-write bit vector for long-latency destinations. One set
//            port (issue) and one clear port (retire); set wins when both hit
//            the same register. Bit 0 (x0) is held at 0.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            set_en, set_addr  - mark a register pending next cycle
//            clr_en, clr_addr  - clear a register's pending bit next cycle
//            pending           - current pending vector
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_sb_regfile
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = REG_ADDR_BUS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [REG_AW-1:0]    set_addr,
  input  logic                 clr_en,
  input  logic [REG_AW-1:0]    clr_addr,
  output logic [2**REG_AW-1:0] pending
);

  localparam int NREG = 2 ** REG_AW;

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en) pending_d[set_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : ID-stage hazard unit. Combines the EX load-use check with a
//            register scoreboard for long-latency writers (variable-latency
//            loads, mul/div), bounds in-flight writers to MAX_OUTST, and
//            arbitrates taken-jump flush over stall.
// Ports    : id_*            - ID instruction operands/destination/flags
//            ex_*            - EX destination, load flag, resolved jump
//            wb_long_*       - long-latency writeback this cycle
//            pc_stall, if_id_stall, if_id_flush, id_ex_flush - pipe controls
//            sb_pending      - pending vector; sb_full - in-flight at limit
// Macro    : HAZARD_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW    = REG_ADDR_BUS,
  parameter int MAX_OUTST = 4,
  parameter int WB_BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_AW-1:0]    id_rs1,
  input  logic [REG_AW-1:0]    id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_AW-1:0]    id_rd,
  input  logic                 id_rd_we,
  input  logic                 id_long,
  input  logic                 ex_valid,
  input  logic [REG_AW-1:0]    ex_rd,
  input  logic                 ex_rmem,
  input  logic                 ex_jump,
  input  logic                 wb_long_valid,
  input  logic [REG_AW-1:0]    wb_long_rd,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic [2**REG_AW-1:0] sb_pending,
  output logic                 sb_full
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  localparam int              CNT_W   = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             BYP_EN  = (WB_BYPASS != 0);

  logic [CNT_W-1:0] out_cnt_q;
  logic [CNT_W-1:0] out_cnt_d;

  logic [2**REG_AW-1:0] pending;
  logic lu, raw, waw, cap, stall, issue, retire;
  logic rs1_pend, rs2_pend, rd_pend;

  // A register completing its long writeback this cycle is treated as
  // already written when the regfile writes through.
  always_comb begin
    rs1_pend = pending[id_rs1] & ~(BYP_EN & wb_long_valid & (wb_long_rd == id_rs1));
    rs2_pend = pending[id_rs2] & ~(BYP_EN & wb_long_valid & (wb_long_rd == id_rs2));
    rd_pend  = pending[id_rd]  & ~(BYP_EN & wb_long_valid & (wb_long_rd == id_rd));

    lu  = id_valid & ex_valid & ex_rmem & (ex_rd != '0) &
          ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    raw = id_valid & ((id_rs1_used & rs1_pend) | (id_rs2_used & rs2_pend));
    waw = id_valid & id_rd_we & (id_rd != '0) & rd_pend;
    // A same-cycle retire frees a slot, so the new writer may take it.
    cap = id_valid & id_long & (out_cnt_q == CNT_MAX) & ~wb_long_valid;

    // Jump kills the ID instruction, so it has nothing to wait for.
    stall  = (hz_prio(lu, raw, waw, cap) != HZ_NONE) & ~ex_jump;
    issue  = id_valid & id_long & id_rd_we & ~stall & ~ex_jump;
    retire = wb_long_valid;
  end

  assign pc_stall    = stall;
  assign if_id_stall = stall;
  assign id_ex_flush = stall | ex_jump;
  assign if_id_flush = ex_jump;
  assign sb_pending  = pending;
  assign sb_full     = (out_cnt_q == CNT_MAX);

  hazard_scoreboard_sb_regfile #(
    .REG_AW (REG_AW)
  ) u_sb_regfile (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue),
    .set_addr (id_rd),
    .clr_en   (retire),
    .clr_addr (wb_long_rd),
    .pending  (pending)
  );

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (issue && !retire && (out_cnt_q != CNT_MAX)) begin
      out_cnt_d = out_cnt_q + CNT_ONE;
    end else if (retire && !issue && (out_cnt_q != '0)) begin
      out_cnt_d = out_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out_cnt_q <= '0;
    else     out_cnt_q <= out_cnt_d;
  end

  // A writeback with nothing outstanding means the long units and this
  // scoreboard disagree about what is in flight.
  always_ff @(posedge clk) begin
    if (!rst && wb_long_valid) begin
      assert (out_cnt_q != '0)
        else $error("hazard_scoreboard: long writeback with no writer outstanding");
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    perf_flush_cnt_d = perf_flush_cnt_q;
    if (stall)   perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    if (ex_jump) perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed self-checking bench for hazard_scoreboard. Two
//            instances share stimulus: u_dut (WB_BYPASS=1) and u_dut_nb
//            (WB_BYPASS=0). HAZARD_PERF_CNT_EN enables the counter checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic       clk, rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_long;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, wb_long_rd;
  logic       ex_valid, ex_rmem, ex_jump, wb_long_valid;

  logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush, sb_full;
  logic [31:0] sb_pending;
  logic        b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_flush, b_sb_full;
  logic [31:0] b_sb_pending;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, b_perf_stall_cnt, b_perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.REG_AW(5), .MAX_OUTST(4), .WB_BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_long(id_long), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_rmem(ex_rmem), .ex_jump(ex_jump), .wb_long_valid(wb_long_valid),
    .wb_long_rd(wb_long_rd), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .sb_pending(sb_pending),
    .sb_full(sb_full)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  hazard_scoreboard #(.REG_AW(5), .MAX_OUTST(4), .WB_BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_long(id_long), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_rmem(ex_rmem), .ex_jump(ex_jump), .wb_long_valid(wb_long_valid),
    .wb_long_rd(wb_long_rd), .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall),
    .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush), .sb_pending(b_sb_pending),
    .sb_full(b_sb_full)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(b_perf_stall_cnt), .perf_flush_cnt(b_perf_flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_we = 0; id_long = 0;
    ex_valid = 0; ex_rd = 0; ex_rmem = 0; ex_jump = 0;
    wb_long_valid = 0; wb_long_rd = 0;
  endtask

  task automatic id_set(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic we,
                        input logic lng);
    id_valid = 1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we; id_long = lng;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd);
    wb_long_valid = v;
    wb_long_rd    = rd;
  endtask

  // Issue a long op to rd (sources unused, must not stall), then go idle.
  task automatic issue_long(input logic [4:0] rd);
    idle();
    id_set(5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 1'b1);
    #1;
    chk("issue_nostall", {31'd0, pc_stall}, 32'd0);
    step();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_pc_stall",    {31'd0, pc_stall},    32'd0);
    chk("rst_if_id_stall", {31'd0, if_id_stall}, 32'd0);
    chk("rst_if_id_flush", {31'd0, if_id_flush}, 32'd0);
    chk("rst_id_ex_flush", {31'd0, id_ex_flush}, 32'd0);
    chk("rst_pending",     sb_pending,           32'd0);
    chk("rst_full",        {31'd0, sb_full},     32'd0);

    // Load-use: EX lw x5, ID add x6,x5,x1
    idle();
    ex_valid = 1; ex_rmem = 1; ex_rd = 5'd5;
    id_set(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    chk("lu_pc_stall",    {31'd0, pc_stall},    32'd1);
    chk("lu_if_id_stall", {31'd0, if_id_stall}, 32'd1);
    chk("lu_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    chk("lu_if_id_flush", {31'd0, if_id_flush}, 32'd0);
    step();
    ex_valid = 0; ex_rmem = 0; ex_rd = 5'd0;
    #1;
    chk("lu_release",       {31'd0, pc_stall},    32'd0);
    chk("lu_release_flush", {31'd0, id_ex_flush}, 32'd0);
    ex_valid = 1; ex_rmem = 1; ex_rd = 5'd0;
    id_set(5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    chk("lu_x0", {31'd0, pc_stall}, 32'd0);
    step();

    // Long div to x7, dependent read held until writeback
    issue_long(5'd7);
    chk("div_pend", sb_pending, 32'h0000_0080);
    for (int c = 1; c <= 5; c++) begin
      id_set(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
      #1;
      chk("div_hold_byp",   {31'd0, pc_stall},   32'd1);
      chk("div_hold_nobyp", {31'd0, b_pc_stall}, 32'd1);
      step();
    end
    wb(1'b1, 5'd7);
    #1;
    chk("div_wb_byp",   {31'd0, pc_stall},   32'd0);
    chk("div_wb_nobyp", {31'd0, b_pc_stall}, 32'd1);
    step();
    wb(1'b0, 5'd0);
    #1;
    chk("div_after_nobyp",   {31'd0, b_pc_stall}, 32'd0);
    chk("div_pend_clr",      sb_pending,          32'd0);
    chk("div_pend_clr_nb",   b_sb_pending,        32'd0);
    step();
    idle();

    // Capacity: four in flight, fifth waits unless a slot frees this cycle
    for (int r = 1; r <= 4; r++) issue_long(5'(r));
    chk("cap_pend", sb_pending, 32'h0000_001E);
    chk("cap_full", {31'd0, sb_full}, 32'd1);
    id_set(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    #1;
    chk("cap_stall", {31'd0, pc_stall},    32'd1);
    chk("cap_flush", {31'd0, id_ex_flush}, 32'd1);
    wb(1'b1, 5'd1);
    #1;
    chk("cap_wb_pass", {31'd0, pc_stall}, 32'd0);
    step();
    idle();
    #1;
    chk("cap_pend2", sb_pending, 32'h0000_011C);
    chk("cap_full2", {31'd0, sb_full}, 32'd1);
    wb(1'b1, 5'd2); step();
    wb(1'b1, 5'd3); step();
    wb(1'b1, 5'd4); step();
    wb(1'b1, 5'd8); step();
    wb(1'b0, 5'd0);
    #1;
    chk("drain_pend", sb_pending, 32'd0);
    chk("drain_full", {31'd0, sb_full}, 32'd0);

    // Jump overrides an active RAW stall; the long op in ID must not issue
    issue_long(5'd10);
    id_set(5'd0, 1'b0, 5'd10, 1'b1, 5'd11, 1'b1, 1'b1);
    #1;
    chk("jmp_raw", {31'd0, pc_stall}, 32'd1);
    ex_jump = 1'b1;
    #1;
    chk("jmp_pc_stall",    {31'd0, pc_stall},    32'd0);
    chk("jmp_if_id_stall", {31'd0, if_id_stall}, 32'd0);
    chk("jmp_if_id_flush", {31'd0, if_id_flush}, 32'd1);
    chk("jmp_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    step();
    idle();
    #1;
    chk("jmp_pend", sb_pending, 32'h0000_0400);
    wb(1'b1, 5'd10);
    step();
    wb(1'b0, 5'd0);
    #1;
    chk("jmp_pend_clr", sb_pending, 32'd0);

    // Same-cycle retire and re-issue of x9: set wins, count unchanged
    issue_long(5'd9);
    chk("x9_pend", sb_pending, 32'h0000_0200);
    id_set(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    wb(1'b1, 5'd9);
    #1;
    chk("x9_nostall", {31'd0, pc_stall}, 32'd0);
    step();
    idle();
    #1;
    chk("x9_pend_set", sb_pending, 32'h0000_0200);
    issue_long(5'd12);
    issue_long(5'd13);
    chk("x9_cnt3", {31'd0, sb_full}, 32'd0);
    issue_long(5'd14);
    chk("x9_cnt4", {31'd0, sb_full}, 32'd1);

    // Reset pulse in the middle of an issue
    id_set(5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    #1;
    chk("mrst_pend", sb_pending, 32'd0);
    chk("mrst_full", {31'd0, sb_full}, 32'd0);
    for (int r = 1; r <= 3; r++) issue_long(5'(r));
    chk("mrst_cnt3", {31'd0, sb_full}, 32'd0);
    issue_long(5'd4);
    chk("mrst_cnt4", {31'd0, sb_full}, 32'd1);

`ifdef HAZARD_PERF_CNT_EN
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    ex_valid = 1; ex_rmem = 1; ex_rd = 5'd5;
    id_set(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    repeat (3) step();
    idle();
    ex_jump = 1'b1;
    repeat (2) step();
    idle();
    #1;
    chk("perf_stall", perf_stall_cnt, 32'd3);
    chk("perf_flush", perf_flush_cnt, 32'd2);
    chk("perf_stall_nb", b_perf_stall_cnt, 32'd3);
    chk("perf_flush_nb", b_perf_flush_cnt, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
